// File: rtl/regfile_dump_sequencer.sv
// Streams every general-purpose register out over a byte-wide valid/ready port.
// Drives the decode-stage debug read address and serializes each word LSB byte first.
module regfile_dump_sequencer #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned N_REGS  = 32,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [NB_DATA-1:0] i_reg_data,
    output logic               o_br_enable,
    output logic [NB_REG-1:0]  o_br_addr,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_IDX-1:0] LAST_IDX  = NB_IDX'(N_BYTES - 1);
    localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(N_REGS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLatch,
        StSend,
        StDone
    } state_e;

    state_e              state_q;
    logic [NB_DATA-1:0]  shift_q;
    logic [NB_IDX-1:0]   index_q;
    logic [NB_REG-1:0]   addr_q;
    logic                br_enable_q;
    logic                tx_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                handshake;

    assign handshake = tx_valid_q & i_tx_ready;

    // Abort in IDLE lands on the same values IDLE already holds, so it shares the reset path.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_abort) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            index_q     <= '0;
            addr_q      <= '0;
            br_enable_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q     <= StLatch;
                        addr_q      <= '0;
                        br_enable_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                StLatch: begin
                    shift_q    <= i_reg_data;
                    index_q    <= '0;
                    tx_valid_q <= 1'b1;
                    state_q    <= StSend;
                end
                StSend: begin
                    if (handshake) begin
                        shift_q <= shift_q >> NB_BYTE;
                        if (index_q == LAST_IDX) begin
                            tx_valid_q <= 1'b0;
                            index_q    <= '0;
                            if (addr_q == LAST_ADDR) begin
                                state_q     <= StDone;
                                br_enable_q <= 1'b0;
                                done_q      <= 1'b1;
                            end else begin
                                addr_q  <= addr_q + NB_REG'(1);
                                state_q <= StLatch;
                            end
                        end else begin
                            index_q <= index_q + NB_IDX'(1);
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    addr_q  <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_br_enable = br_enable_q;
    assign o_br_addr   = addr_q;
    assign o_tx_data   = shift_q[NB_BYTE-1:0];
    assign o_tx_valid  = tx_valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// Directed bench for regfile_dump_sequencer: register bank model reg[k] = 0x11223300 + k.
// Inputs change and outputs are sampled on the falling edge.
module tb_regfile_dump_sequencer;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [31:0] i_reg_data;
    logic        o_br_enable;
    logic [4:0]  o_br_addr;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Results of the last run_dump call
    logic [7:0] bytes_q[$];
    int         done_cnt;
    int         done_off;
    int         end_off;
    int         ready_low;
    int         stable_err;
    bit         timed_out;
    logic       lat_en;
    logic [4:0] lat_addr;
    logic       lat_valid;
    logic       end_en;
    logic       end_valid;
    logic [7:0] end_data;

    always #5 i_clock = ~i_clock;

    assign i_reg_data = 32'h1122_3300 + 32'(o_br_addr);

    regfile_dump_sequencer dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_reg_data  (i_reg_data),
        .o_br_enable (o_br_enable),
        .o_br_addr   (o_br_addr),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        else
            n_pass++;
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = 32'h1122_3300 + 32'(i / 4);
        return w[8*(i%4) +: 8];
    endfunction

    // Starts a dump and follows it until o_busy falls. Offset 1 is the cycle after the
    // edge that samples i_start. Negative arguments disable the corresponding event.
    task automatic run_dump(input bit rand_ready, input int restart_at, input int abort_byte,
                            input int reset_at);
        bit         hold;
        logic [7:0] hold_data;
        bit         kill;
        bytes_q.delete();
        done_cnt = 0; done_off = -1; end_off = -1; ready_low = 0; stable_err = 0;
        timed_out = 1'b1; hold = 1'b0; hold_data = '0;
        @(negedge i_clock);
        i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            if (k == 1) begin
                lat_en = o_br_enable; lat_addr = o_br_addr; lat_valid = o_tx_valid;
            end
            if (hold && (!o_tx_valid || o_tx_data !== hold_data)) stable_err++;
            if (k > 1 && !o_busy) begin
                end_off = k; end_en = o_br_enable; end_valid = o_tx_valid; end_data = o_tx_data;
                timed_out = 1'b0;
                break;
            end
            i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            i_start    = (k == restart_at);
            i_abort    = (abort_byte >= 0) && o_tx_valid && (bytes_q.size() == abort_byte);
            i_reset    = (k == reset_at);
            kill       = i_abort || i_reset;
            if (o_done) begin done_cnt++; done_off = k; end
            if (o_tx_valid && i_tx_ready && !kill) bytes_q.push_back(o_tx_data);
            if (o_tx_valid && !i_tx_ready) ready_low++;
            hold = o_tx_valid && !i_tx_ready && !kill;
            hold_data = o_tx_data;
            @(negedge i_clock);
        end
        i_start = 1'b0; i_abort = 1'b0; i_reset = 1'b0; i_tx_ready = 1'b0;
        if (timed_out) check("dump_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_sequence(input string tag, input int n);
        int err;
        err = 0;
        check({tag, "_count"}, 32'(bytes_q.size()), 32'(n));
        for (int i = 0; i < n && i < bytes_q.size(); i++)
            if (bytes_q[i] !== exp_byte(i)) err++;
        check({tag, "_bytes"}, 32'(err), 32'd0);
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(negedge i_clock);
        i_reset = 1'b0;
        check("rst_br_enable", 32'(o_br_enable), 32'd0);
        check("rst_br_addr", 32'(o_br_addr), 32'd0);
        check("rst_tx_data", 32'(o_tx_data), 32'd0);
        check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        for (int i = 0; i < 6; i++) begin
            i_tx_ready = ~i_tx_ready;
            @(negedge i_clock);
            check("idle_no_valid", 32'(o_tx_valid | o_busy), 32'd0);
        end
        i_tx_ready = 1'b0;

        // Abort and start together in IDLE: abort wins
        i_start = 1'b1; i_abort = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0; i_abort = 1'b0;
        check("abort_start_idle_busy", 32'(o_busy), 32'd0);
        check("abort_start_idle_en", 32'(o_br_enable), 32'd0);

        // Full dump, continuous ready
        run_dump(1'b0, -1, -1, -1);
        check("latch_en", 32'(lat_en), 32'd1);
        check("latch_addr", 32'(lat_addr), 32'd0);
        check("latch_valid", 32'(lat_valid), 32'd0);
        check_sequence("full", 128);
        if (bytes_q.size() == 128) begin
            check("first_b0", 32'(bytes_q[0]), 32'h00);
            check("first_b1", 32'(bytes_q[1]), 32'h33);
            check("first_b2", 32'(bytes_q[2]), 32'h22);
            check("first_b3", 32'(bytes_q[3]), 32'h11);
            check("last_b0", 32'(bytes_q[124]), 32'h1F);
            check("last_b1", 32'(bytes_q[125]), 32'h33);
            check("last_b2", 32'(bytes_q[126]), 32'h22);
            check("last_b3", 32'(bytes_q[127]), 32'h11);
        end
        check("full_done_cnt", 32'(done_cnt), 32'd1);
        check("full_done_off", 32'(done_off), 32'd161);
        check("full_idle_off", 32'(end_off), 32'd162);
        check("full_idle_addr", 32'(o_br_addr), 32'd0);

        // Random backpressure
        run_dump(1'b1, -1, -1, -1);
        check_sequence("rand", 128);
        check("rand_stable", 32'(stable_err), 32'd0);
        check("rand_done_cnt", 32'(done_cnt), 32'd1);
        check("rand_done_off", 32'(done_off), 32'(161 + ready_low));

        // Start re-pulsed mid-dump is ignored
        run_dump(1'b0, 20, -1, -1);
        check_sequence("restart", 128);
        check("restart_done_cnt", 32'(done_cnt), 32'd1);
        check("restart_done_off", 32'(done_off), 32'd161);

        // Abort during register 5 byte 2
        run_dump(1'b0, -1, 22, -1);
        check_sequence("abort", 22);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        check("abort_en", 32'(end_en), 32'd0);
        check("abort_valid", 32'(end_valid), 32'd0);
        check("abort_addr", 32'(o_br_addr), 32'd0);

        // Fresh start after abort begins again at register 0 byte 0
        run_dump(1'b0, -1, -1, -1);
        check_sequence("after_abort", 128);
        check("after_abort_done", 32'(done_off), 32'd161);

        // Reset at offset 50 drops the in-flight byte (reg 9 byte 3)
        run_dump(1'b0, -1, -1, 50);
        check_sequence("reset", 39);
        check("reset_end_off", 32'(end_off), 32'd51);
        check("reset_en", 32'(end_en), 32'd0);
        check("reset_valid", 32'(end_valid), 32'd0);
        check("reset_data", 32'(end_data), 32'd0);
        check("reset_done_cnt", 32'(done_cnt), 32'd0);
        i_tx_ready = 1'b1;
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge i_clock);
                if (o_tx_valid || o_busy || o_done) stray++;
            end
            check("reset_quiet", 32'(stray), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump_sequencer.md
# regfile_dump_sequencer

Debug-path controller that takes over the decode-stage register bank's debug read port after a halt and streams all general-purpose registers out through a byte-wide valid/ready interface toward the UART TX path. It drives the debug read address and enable into the decode stage, captures each 32-bit register value, and serializes it LSB-byte first. It is a handshake-paced FSM and never stalls or alters the pipeline itself.

## Interface
Parameters:
- NB_DATA, 32, register width; must be a multiple of NB_BYTE
- NB_REG, 5, register address width
- N_REGS, 32, number of registers dumped (addresses 0..N_REGS-1)
- NB_BYTE, 8, output byte width

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  dump request; sampled only in IDLE
- i_abort  in  1  cancel dump; returns to IDLE next cycle, no o_done
- i_reg_data  in  NB_DATA  register read data from decode debug port (combinational w.r.t. o_br_addr)
- o_br_enable  out  1  selects debug address on register bank read port A
- o_br_addr  out  NB_REG  debug register address
- o_tx_data  out  NB_BYTE  byte to transmit
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  consumer accepts byte when o_tx_valid & i_tx_ready
- o_busy  out  1  high in LATCH, SEND, DONE
- o_done  out  1  one-cycle pulse on dump completion

## Operation
- States: IDLE, LATCH, SEND, DONE.
- IDLE: o_br_enable=0, o_br_addr=0, o_tx_valid=0. If i_start=1 -> LATCH with addr=0.
- LATCH: o_br_enable=1; capture i_reg_data into shift register; byte index=0; -> SEND.
- SEND: o_br_enable=1, o_tx_valid=1, o_tx_data=shift[NB_BYTE-1:0]. On handshake: shift right by NB_BYTE, index++. On handshake of byte NB_DATA/NB_BYTE-1: if addr==N_REGS-1 -> DONE, else addr++ -> LATCH.
- DONE: o_done=1, o_br_enable=0, o_tx_valid=0; -> IDLE, addr cleared.
- Without handshake, o_tx_data and o_tx_valid hold stable; o_tx_valid never drops before acceptance (except abort/reset).
- i_start in LATCH/SEND/DONE ignored; not queued.
- i_abort has priority over all transitions in every non-IDLE state: next state IDLE, outputs at IDLE values, byte in flight dropped. i_abort in IDLE: no effect. i_abort and i_start together in IDLE: abort wins, stay IDLE.
- Address counter is NB_REG wide; terminal compare on N_REGS-1 so no wrap occurs for N_REGS=2^NB_REG.

## Timing
- Reset: state IDLE; o_br_enable=0, o_br_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, shift register and index 0. Reset mid-dump behaves as abort, same cycle priority over i_abort.
- i_start sampled high at edge t: cycle t+1 LATCH (o_br_addr=0, o_br_enable=1); t+2 first byte valid.
- Register k (i_tx_ready held 1): LATCH at t+1+5k, bytes at t+2+5k..t+5+5k.
- Full dump with continuous ready: 5*N_REGS cycles, DONE at t+161, IDLE at t+162 (N_REGS=32).
- Each ready-low cycle in SEND adds exactly one cycle.
- o_br_addr changes only on LATCH entry; i_reg_data captured one cycle after address is stable.

## Test plan
- Reset then idle: all outputs 0; i_tx_ready toggling produces no valid.
- Registers preloaded reg[k]=0x11223300+k, i_start pulse, ready=1: 128 bytes, first four 0x00,0x33,0x22,0x11, last four 0x1F,0x33,0x22,0x11; o_done at t+161 only.
- Ready random 50%: same byte sequence; o_tx_data stable whenever valid&!ready; total cycles = 160 + ready-low SEND cycles + 1.
- i_start re-pulsed at t+20: ignored, output sequence unchanged, single o_done.
- i_abort during reg 5 byte 2: next cycle IDLE, o_br_enable=0, no o_done; new i_start restarts at reg 0 byte 0.
- i_reset at t+50: next cycle all outputs reset values; no further bytes.
